// File: rtl/keycode_lane_decoder_pkg.sv
// Shared types for the keycode lane decoder: event record, FSM states, FIFO depth.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package keycode_lane_decoder_pkg;

   localparam int EVT_FIFO_DEPTH = 8;

   typedef struct packed {
      logic [1:0]  lane;
      logic        press;
      logic [15:0] ts;
   } evt_t;

   localparam int EVT_W = $bits(evt_t);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PUSH_REL   = 2'd1,
      ST_PUSH_PRESS = 2'd2
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] lane;
   } lane_map_t;

   // Map a HID usage code onto one of the four lanes; anything else is "no lane".
   function automatic lane_map_t map_code(input logic [7:0] code,
                                          input logic [7:0] c0,
                                          input logic [7:0] c1,
                                          input logic [7:0] c2,
                                          input logic [7:0] c3);
      lane_map_t m;
      m.hit  = 1'b1;
      m.lane = 2'd0;
      if (code == c0)      m.lane = 2'd0;
      else if (code == c1) m.lane = 2'd1;
      else if (code == c2) m.lane = 2'd2;
      else if (code == c3) m.lane = 2'd3;
      else                 m.hit  = 1'b0;
      return m;
   endfunction

   function automatic logic [3:0] lane_onehot(input lane_map_t m);
      return m.hit ? (4'b0001 << m.lane) : 4'b0000;
   endfunction

endpackage

// File: rtl/keycode_lane_decoder_if.sv
// Event stream bus between the lane decoder and its consumer.
// Latency: n/a (wiring only).
// Backpressure: evt_valid/evt_ready handshake; ovf_clr is a one-cycle pulse from the consumer.
interface keycode_lane_decoder_if;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_lane;
   logic        evt_press;
   logic [15:0] evt_ts;
   logic        evt_ovf;
   logic        ovf_clr;

   modport master (
      output evt_valid, evt_lane, evt_press, evt_ts, evt_ovf,
      input  evt_ready, ovf_clr
   );

   modport slave (
      input  evt_valid, evt_lane, evt_press, evt_ts, evt_ovf,
      output evt_ready, ovf_clr
   );
endinterface

// File: rtl/keycode_lane_decoder_event_fifo.sv
// Generic first-word fall-through FIFO for lane events.
// Latency: a write is visible at rd_dat/rd_vld one edge after it is stored.
// Backpressure: writes while full are dropped (drop pulses) unless a pop happens on the same edge.
module event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 19
) (
   input  logic             Clk,
   input  logic             Reset_h,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             drop
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             pop;
   logic             push;

   // An empty FIFO never pops, so a simultaneous write+ready there simply stores.
   assign rd_vld = (count != '0);
   assign full   = (count == CW'(DEPTH));
   assign pop    = rd_vld && rd_rdy;
   assign push   = wr_vld && (!full || pop);
   assign drop   = wr_vld && full && !pop;
   assign rd_dat = mem[rd_ptr];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Storage array; contents are don't-care until a pointer covers them.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/keycode_lane_decoder.sv
// Debounces the SoC keycode word, tracks the held lane and queues timestamped press/release events.
// Latency: lane_held on the commit edge; first event visible on evt_* two edges after commit.
// Backpressure: 8-deep event FIFO; overflowing writes are dropped and flagged on evt_ovf.
module keycode_lane_decoder
   import keycode_lane_decoder_pkg::*;
#(
   parameter int         FILTER_CYCLES = 1000,
   parameter int         PRESCALE      = 50000,
   parameter logic [7:0] LANE0_CODE    = 8'h07,
   parameter logic [7:0] LANE1_CODE    = 8'h09,
   parameter logic [7:0] LANE2_CODE    = 8'h0D,
   parameter logic [7:0] LANE3_CODE    = 8'h0E
) (
   input  logic                   Clk,
   input  logic                   Reset_h,
   input  logic [7:0]             keycode,
   output logic [3:0]             lane_held,
   keycode_lane_decoder_if.master evt_bus
);
   logic [31:0] pre_cnt;
   logic [15:0] ts;
   logic [7:0]  cand;
   logic [15:0] filt_cnt;
   logic [15:0] filt_cnt_nxt;
   logic [7:0]  committed;
   logic        commit;
   state_t      state;
   lane_map_t   cur_map;
   lane_map_t   key_map;
   lane_map_t   press_map;
   logic [1:0]  rel_lane;
   logic [15:0] ts_cap;
   logic        wr_vld;
   evt_t        wr_dat;
   evt_t        head_evt;
   logic        fifo_drop;
   logic        ovf;

   // Timestamp tick generator: ts advances once per PRESCALE clocks and wraps naturally.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         pre_cnt <= '0;
         ts      <= '0;
      end else if (pre_cnt == 32'(PRESCALE - 1)) begin
         pre_cnt <= '0;
         ts      <= ts + 16'd1;
      end else begin
         pre_cnt <= pre_cnt + 32'd1;
      end
   end

   // Run-length of the current candidate, saturating at the filter length.
   always_comb begin
      filt_cnt_nxt = filt_cnt;
      if (keycode != cand)
         filt_cnt_nxt = 16'd1;
      else if (filt_cnt != 16'(FILTER_CYCLES))
         filt_cnt_nxt = filt_cnt + 16'd1;
   end

   // The candidate always follows the input; only the count distinguishes a stable code.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         cand     <= 8'h00;
         filt_cnt <= '0;
      end else begin
         cand     <= keycode;
         filt_cnt <= filt_cnt_nxt;
      end
   end

   // The post-edge candidate is always keycode, so a stable code commits as keycode itself.
   // A saturated count left pending while busy commits on the first IDLE edge.
   assign cur_map = map_code(committed, LANE0_CODE, LANE1_CODE, LANE2_CODE, LANE3_CODE);
   assign key_map = map_code(keycode,   LANE0_CODE, LANE1_CODE, LANE2_CODE, LANE3_CODE);
   assign commit  = (state == ST_IDLE) && (filt_cnt_nxt == 16'(FILTER_CYCLES)) &&
                    (keycode != committed);

   // Commit/event FSM: release of the old lane first, then press of the new one, both
   // carrying the commit-edge timestamp; the FIFO write strobe is registered.
   always_ff @(posedge Clk) begin
      if (Reset_h) begin
         state     <= ST_IDLE;
         committed <= 8'h00;
         lane_held <= 4'b0000;
         ts_cap    <= '0;
         rel_lane  <= '0;
         press_map <= '0;
         wr_vld    <= 1'b0;
         wr_dat    <= '0;
      end else begin
         wr_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (commit) begin
                  committed <= keycode;
                  lane_held <= lane_onehot(key_map);
                  ts_cap    <= ts;
                  rel_lane  <= cur_map.lane;
                  press_map <= key_map;
                  if (cur_map.hit)      state <= ST_PUSH_REL;
                  else if (key_map.hit) state <= ST_PUSH_PRESS;
               end
            end
            ST_PUSH_REL: begin
               wr_vld <= 1'b1;
               wr_dat <= {rel_lane, 1'b0, ts_cap};
               state  <= press_map.hit ? ST_PUSH_PRESS : ST_IDLE;
            end
            ST_PUSH_PRESS: begin
               wr_vld <= 1'b1;
               wr_dat <= {press_map.lane, 1'b1, ts_cap};
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   event_fifo #(
      .DEPTH (EVT_FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .Clk     (Clk),
      .Reset_h (Reset_h),
      .wr_vld  (wr_vld),
      .wr_dat  (wr_dat),
      .rd_vld  (evt_bus.evt_valid),
      .rd_rdy  (evt_bus.evt_ready),
      .rd_dat  (head_evt),
      .drop    (fifo_drop)
   );

   // Sticky overflow flag; a drop on the clear edge wins so no loss goes unreported.
   always_ff @(posedge Clk) begin
      if (Reset_h)              ovf <= 1'b0;
      else if (fifo_drop)       ovf <= 1'b1;
      else if (evt_bus.ovf_clr) ovf <= 1'b0;
   end

   assign evt_bus.evt_lane  = head_evt.lane;
   assign evt_bus.evt_press = head_evt.press;
   assign evt_bus.evt_ts    = head_evt.ts;
   assign evt_bus.evt_ovf   = ovf;
endmodule

// File: tb/tb_keycode_lane_decoder.sv
// Self-checking bench for keycode_lane_decoder: directed table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: evt_ready driven directly (held low, pulsed, or random).
module tb_keycode_lane_decoder;
   import keycode_lane_decoder_pkg::*;

   localparam int F = 4;
   localparam int P = 1;

   logic       Clk = 1'b0;
   logic       Reset_h = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic [3:0] lane_held;

   keycode_lane_decoder_if bus();

   keycode_lane_decoder #(
      .FILTER_CYCLES (F),
      .PRESCALE      (P),
      .LANE0_CODE    (8'h07),
      .LANE1_CODE    (8'h09),
      .LANE2_CODE    (8'h0D),
      .LANE3_CODE    (8'h0E)
   ) dut (
      .Clk       (Clk),
      .Reset_h   (Reset_h),
      .keycode   (keycode),
      .lane_held (lane_held),
      .evt_bus   (bus)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         @(negedge Clk);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint     edge_no;
      evt_t       e;
   } sched_t;

   evt_t       m_fifo[$];
   sched_t     m_sched[$];
   longint     m_edge = 0;
   logic [7:0] m_prev = 8'h00;
   int         m_run = 0;
   logic [7:0] m_comm = 8'h00;
   longint     m_busy_until = 0;
   logic [3:0] m_held = 4'b0000;
   logic       m_ovf = 1'b0;
   logic       chk_en = 1'b0;

   function automatic int lane_of(input logic [7:0] c);
      case (c)
         8'h07:   return 0;
         8'h09:   return 1;
         8'h0D:   return 2;
         8'h0E:   return 3;
         default: return -1;
      endcase
   endfunction

   always @(posedge Clk) begin
      logic [15:0] ts_now;
      logic        do_pop, have_wr, drop;
      evt_t        wr;
      int          o, n, cnt;
      sched_t      s;
      if (Reset_h) begin
         m_fifo.delete();
         m_sched.delete();
         m_edge = 0; m_prev = 8'h00; m_run = 0; m_comm = 8'h00;
         m_busy_until = 0; m_held = 4'b0000; m_ovf = 1'b0;
      end else begin
         ts_now = 16'((m_edge / P) % 65536);
         if (keycode == m_prev) m_run++;
         else begin m_prev = keycode; m_run = 1; end
         do_pop  = (m_fifo.size() > 0) && bus.evt_ready;
         have_wr = (m_sched.size() > 0) && (m_sched[0].edge_no == m_edge);
         wr = '0;
         drop = 1'b0;
         if (have_wr) begin wr = m_sched[0].e; void'(m_sched.pop_front()); end
         if (do_pop) void'(m_fifo.pop_front());
         if (have_wr) begin
            if (m_fifo.size() < 8) m_fifo.push_back(wr);
            else drop = 1'b1;
         end
         if (drop) m_ovf = 1'b1;
         else if (bus.ovf_clr) m_ovf = 1'b0;
         if (m_run >= F && keycode != m_comm && m_edge >= m_busy_until) begin
            o = lane_of(m_comm);
            n = lane_of(keycode);
            cnt = 0;
            if (o >= 0) begin
               s.edge_no = m_edge + 2 + cnt; s.e = {2'(o), 1'b0, ts_now};
               m_sched.push_back(s); cnt++;
            end
            if (n >= 0) begin
               s.edge_no = m_edge + 2 + cnt; s.e = {2'(n), 1'b1, ts_now};
               m_sched.push_back(s); cnt++;
            end
            m_busy_until = m_edge + cnt + 1;
            m_comm = keycode;
            m_held = (n >= 0) ? 4'(1 << n) : 4'b0000;
         end
         m_edge++;
      end
   end

   logic        prev_head_vld = 1'b0;
   logic [15:0] prev_head_ts = '0;
   logic        wrap_seen = 1'b0;

   always @(negedge Clk) begin
      if (chk_en) begin
         check("model_valid", 32'(bus.evt_valid), 32'(m_fifo.size() > 0));
         check("model_held", 32'(lane_held), 32'(m_held));
         check("model_ovf", 32'(bus.evt_ovf), 32'(m_ovf));
         if (bus.evt_valid && m_fifo.size() > 0) begin
            check("model_lane", 32'(bus.evt_lane), 32'(m_fifo[0].lane));
            check("model_press", 32'(bus.evt_press), 32'(m_fifo[0].press));
            check("model_ts", 32'(bus.evt_ts), 32'(m_fifo[0].ts));
            if (prev_head_vld && prev_head_ts >= 16'hFF00 && bus.evt_ts < 16'h0100)
               wrap_seen = 1'b1;
            prev_head_vld = 1'b1;
            prev_head_ts  = bus.evt_ts;
         end
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0] key;
      int         hold;
      logic [3:0] exp_held;
      logic       exp_vld;
   } vec_t;

   vec_t       vecs[12];
   logic [7:0] codes[6];

   initial begin
      int         n;
      logic [1:0] last_lane;
      logic       last_press;

      vecs[0]  = '{8'h07, 8, 4'b0001, 1'b0};
      vecs[1]  = '{8'h0D, 8, 4'b0100, 1'b0};
      vecs[2]  = '{8'h09, 3, 4'b0100, 1'b0};
      vecs[3]  = '{8'h0D, 8, 4'b0100, 1'b0};
      vecs[4]  = '{8'h00, 8, 4'b0000, 1'b0};
      vecs[5]  = '{8'h0E, 8, 4'b1000, 1'b0};
      vecs[6]  = '{8'h55, 8, 4'b0000, 1'b0};
      vecs[7]  = '{8'h09, 8, 4'b0010, 1'b0};
      vecs[8]  = '{8'h0A, 2, 4'b0010, 1'b0};
      vecs[9]  = '{8'h09, 8, 4'b0010, 1'b0};
      vecs[10] = '{8'h07, 3, 4'b0010, 1'b0};
      vecs[11] = '{8'h0E, 8, 4'b1000, 1'b0};
      codes = '{8'h07, 8'h09, 8'h0D, 8'h0E, 8'h00, 8'h55};

      bus.evt_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
      tick(2);
      check("reset_held", 32'(lane_held), 32'h0);
      check("reset_valid", 32'(bus.evt_valid), 32'h0);
      check("reset_ovf", 32'(bus.evt_ovf), 32'h0);
      Reset_h = 1'b0;
      chk_en  = 1'b1;

      // Single press: commit on the 4th edge, event visible two edges later.
      keycode = 8'h07;
      tick(3);
      check("press_pre_commit", 32'(lane_held), 32'h0);
      tick(1);
      check("press_commit_held", 32'(lane_held), 32'b0001);
      check("press_commit_vld", 32'(bus.evt_valid), 32'h0);
      tick(1);
      check("press_plus1_vld", 32'(bus.evt_valid), 32'h0);
      tick(1);
      check("press_plus2_vld", 32'(bus.evt_valid), 32'h1);
      check("press_lane", 32'(bus.evt_lane), 32'h0);
      check("press_dir", 32'(bus.evt_press), 32'h1);
      check("press_ts", 32'(bus.evt_ts), 32'd3);

      // Direct lane change: release lane 0 then press lane 2, same timestamp.
      keycode = 8'h0D;
      tick(4);
      check("swap_held", 32'(lane_held), 32'b0100);
      tick(3);
      bus.evt_ready = 1'b1; tick(1); bus.evt_ready = 1'b0;
      check("swap_rel_lane", 32'(bus.evt_lane), 32'h0);
      check("swap_rel_dir", 32'(bus.evt_press), 32'h0);
      check("swap_rel_ts", 32'(bus.evt_ts), 32'd9);
      bus.evt_ready = 1'b1; tick(1); bus.evt_ready = 1'b0;
      check("swap_press_lane", 32'(bus.evt_lane), 32'h2);
      check("swap_press_dir", 32'(bus.evt_press), 32'h1);
      check("swap_press_ts", 32'(bus.evt_ts), 32'd9);
      bus.evt_ready = 1'b1; tick(2);
      check("swap_drained", 32'(bus.evt_valid), 32'h0);

      // Short glitch never commits.
      keycode = 8'h09; tick(3);
      keycode = 8'h0D; tick(5);
      check("glitch_held", 32'(lane_held), 32'b0100);
      check("glitch_no_evt", 32'(bus.evt_valid), 32'h0);

      for (int i = 0; i < 12; i++) begin
         keycode = vecs[i].key;
         tick(vecs[i].hold);
         check($sformatf("vec%0d_held", i), 32'(lane_held), 32'(vecs[i].exp_held));
         check($sformatf("vec%0d_vld", i), 32'(bus.evt_valid), 32'(vecs[i].exp_vld));
      end

      // Overflow: 9 events with no consumer, then a write landing on a pop edge.
      bus.evt_ready = 1'b0;
      keycode = 8'h07; tick(8);
      keycode = 8'h0E; tick(8);
      keycode = 8'h07; tick(8);
      keycode = 8'h0E; tick(8);
      keycode = 8'h00; tick(8);
      check("ovf_set", 32'(bus.evt_ovf), 32'h1);
      check("ovf_head_lane", 32'(bus.evt_lane), 32'h3);
      check("ovf_head_dir", 32'(bus.evt_press), 32'h0);
      bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
      check("ovf_cleared", 32'(bus.evt_ovf), 32'h0);
      keycode = 8'h07; tick(4); tick(1);
      bus.evt_ready = 1'b1; tick(1); bus.evt_ready = 1'b0;
      check("popwrite_no_ovf", 32'(bus.evt_ovf), 32'h0);
      bus.evt_ready = 1'b1;
      n = 0; last_lane = '0; last_press = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.evt_valid) begin
            n++; last_lane = bus.evt_lane; last_press = bus.evt_press;
         end
         tick(1);
      end
      check("popwrite_count", 32'(n), 32'd8);
      check("popwrite_last_lane", 32'(last_lane), 32'h0);
      check("popwrite_last_dir", 32'(last_press), 32'h1);

      // Reset while releasing with three events queued.
      Reset_h = 1'b1; tick(1); Reset_h = 1'b0;
      bus.evt_ready = 1'b0;
      keycode = 8'h07; tick(8);
      keycode = 8'h0E; tick(8);
      keycode = 8'h0D; tick(4);
      check("rst_pre_state", 32'(dut.state), 32'(ST_PUSH_REL));
      check("rst_pre_vld", 32'(bus.evt_valid), 32'h1);
      Reset_h = 1'b1; tick(1);
      check("rst_vld", 32'(bus.evt_valid), 32'h0);
      check("rst_held", 32'(lane_held), 32'h0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      Reset_h = 1'b0; tick(1);
      check("rst_no_partial", 32'(bus.evt_valid), 32'h0);

      // Random traffic long enough for the timestamp to wrap.
      for (int i = 0; i < 66000; ) begin
         int hold;
         keycode = codes[$urandom_range(0, 5)];
         hold = $urandom_range(1, 12);
         for (int j = 0; j < hold; j++) begin
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            bus.ovf_clr   = ($urandom_range(0, 63) == 0);
            tick(1);
         end
         i += hold;
      end
      bus.ovf_clr = 1'b0;
      bus.evt_ready = 1'b1;
      tick(20);
      check("ts_wrap_seen", 32'(wrap_seen), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/keycode_lane_decoder.md
KEYCODE_LANE_DECODER -- requirements
Module: keycode_lane_decoder

Interface
REQ-001 Parameter FILTER_CYCLES, default 1000, meaning consecutive identical keycode samples required before a keycode is committed (range 1..65535).
REQ-002 Parameter PRESCALE, default 50000, meaning Clk cycles per timestamp tick (1 ms at 50 MHz).
REQ-003 Parameters LANE0_CODE/LANE1_CODE/LANE2_CODE/LANE3_CODE, defaults 8'h07/8'h09/8'h0D/8'h0E, meaning USB HID usage codes for lanes 0..3 (D, F, J, K).
REQ-004 Clk  input  1  system clock; all logic on its rising edge.
REQ-005 Reset_h  input  1  synchronous, active-high reset.
REQ-006 keycode  input  8  keycode word written by the SoC keycode PIO; same clock domain.
REQ-007 ovf_clr  input  1  single-cycle pulse clearing the overflow flag.
REQ-008 lane_held  output  4  one-hot held state of the committed keycode; 0 when no lane key is held.
REQ-009 evt_valid  output  1  event FIFO non-empty.
REQ-010 evt_ready  input  1  consumer accepts the head event when evt_valid is also high.
REQ-011 evt_lane  output  2  lane of the head event.
REQ-012 evt_press  output  1  1 = press, 0 = release.
REQ-013 evt_ts  output  16  timestamp of the head event.
REQ-014 evt_ovf  output  1  sticky flag: an event was dropped.

Function
REQ-015 The timestamp counter shall advance by 1 every PRESCALE Clk cycles and wrap from 16'hFFFF to 0.
REQ-016 The filter shall track a candidate code and a count; if keycode differs from the candidate, the candidate shall load keycode and the count shall load 1.
REQ-017 If keycode equals the candidate, the count shall increment, saturating at FILTER_CYCLES.
REQ-018 The candidate shall be committed on the edge where the count reaches FILTER_CYCLES, provided the FSM is in IDLE and the candidate differs from the committed code.
REQ-019 A code matching no lane code, including 8'h00, shall map to "no lane".
REQ-020 lane_held shall update on the commit edge.
REQ-021 FSM states shall be IDLE, PUSH_REL, PUSH_PRESS.
REQ-022 On commit, IDLE shall go to PUSH_REL if the old code mapped to a lane, else to PUSH_PRESS if the new code mapped to a lane, else stay in IDLE.
REQ-023 PUSH_REL shall write one release event for the old lane, then go to PUSH_PRESS if the new code maps to a lane, else to IDLE.
REQ-024 PUSH_PRESS shall write one press event for the new lane, then go to IDLE.
REQ-025 Each event shall carry the timestamp value captured on the commit edge.
REQ-026 A commit edge shall not itself write an event; the first event write occurs on the next edge, and evt_valid rises one edge after that write.
REQ-027 The filter shall keep counting during PUSH_REL and PUSH_PRESS; a pending commit shall take effect on the first edge back in IDLE.
REQ-028 The event FIFO shall be 8 entries of {lane[1:0], press, ts[15:0]}, with the head presented on the evt_* outputs (first-word fall-through).
REQ-029 A pop shall occur on an edge where evt_valid and evt_ready are both high.
REQ-030 A write while the FIFO is full shall be dropped and set evt_ovf, unless a pop occurs on the same edge, in which case the write shall be accepted.
REQ-031 A simultaneous write and pop on an empty FIFO shall store the write; no pop occurs.
REQ-032 evt_ovf shall clear on ovf_clr; if ovf_clr and a drop occur on the same edge, the flag shall be set.
REQ-033 evt_lane, evt_press and evt_ts shall be don't-care while evt_valid is low.

Reset
REQ-034 On Reset_h, the following shall all be zero: lane_held, evt_valid, evt_ovf, the FIFO pointers and count, the filter count, the candidate and committed codes (8'h00), the timestamp, and the prescaler.
REQ-035 On Reset_h, the FSM shall enter IDLE.
REQ-036 Reset mid-operation shall discard pending and queued events with no partial write.

Structure
REQ-037 A shared package shall hold the event struct (lane, press, ts), the FSM state enum, and the FIFO depth constant.
REQ-038 The FIFO shall be one sub-module, event_fifo, parameterised by depth and width.

Verification
REQ-039 With FILTER_CYCLES=4, hold keycode 8'h07 for 4 cycles -> lane_held=4'b0001 on the 4th edge; one event (lane 0, press, ts=current) with evt_valid high 2 edges later.
REQ-040 Go 8'h07 -> 8'h0D directly -> release lane 0 then press lane 2, in that order, with identical evt_ts; lane_held=4'b0100.
REQ-041 Apply an 8'h09 glitch for 3 cycles with FILTER_CYCLES=4 -> no commit, no events, lane_held unchanged.
REQ-042 Hold evt_ready=0 and generate 9 events -> 8 stored and evt_ovf=1; then evt_ready=1 with a 10th event written on a pop edge -> it is accepted.
REQ-043 Set PRESCALE=2 and run past 2^17 cycles -> evt_ts wraps from 16'hFFFF to 0 within the captured events.
REQ-044 Assert Reset_h while in PUSH_REL with 3 events queued -> the next edge shows evt_valid=0, lane_held=0, and FSM IDLE.
